// File: rtl/aes_pkg.sv
// Shared AES datapath types and the ShiftRows / InvShiftRows source-index maps.
// Used by the ShiftRows buffer as well as the key and MixColumns stages.
package aes_pkg;

    localparam int unsigned AES_BLOCK_BYTES = 16;
    localparam int unsigned AES_BYTE_W      = 8;
    localparam int unsigned AES_IDX_W       = $clog2(AES_BLOCK_BYTES);
    localparam int unsigned AES_NUM_BANKS   = 2;

    typedef logic [AES_BYTE_W-1:0] aes_byte_t;
    typedef logic [AES_IDX_W-1:0]  aes_idx_t;

    // Column-major index 4*c + r; ShiftRows reads from column (c + r) mod 4.
    function automatic aes_idx_t shift_src_idx(input aes_idx_t idx);
        logic [1:0] c;
        logic [1:0] r;
        c = idx[3:2];
        r = idx[1:0];
        return {2'(c + r), r};
    endfunction

    // InvShiftRows reads from column (c - r) mod 4.
    function automatic aes_idx_t inv_shift_src_idx(input aes_idx_t idx);
        logic [1:0] c;
        logic [1:0] r;
        c = idx[3:2];
        r = idx[1:0];
        return {2'(c - r), r};
    endfunction

endpackage

// File: rtl/shift_rows_buffer_if.sv
// Byte-stream handshake bundle: input side from the previous round stage,
// output side toward MixColumns.
interface shift_rows_buffer_if;
    import aes_pkg::*;

    logic      encrypt;
    logic      in_valid;
    logic      in_ready;
    aes_byte_t d_in;
    logic      out_valid;
    logic      out_ready;
    aes_byte_t d_out;
    logic      out_col_last;
    logic      out_blk_last;

    modport master (
        output encrypt, in_valid, d_in, out_ready,
        input  in_ready, out_valid, d_out, out_col_last, out_blk_last
    );

    modport slave (
        input  encrypt, in_valid, d_in, out_ready,
        output in_ready, out_valid, d_out, out_col_last, out_blk_last
    );

endinterface

// File: rtl/shift_rows_bank.sv
// One 16-byte state bank: indexed write port, full flag, per-block mode latch
// and a combinational read that applies the (inverse) row shift.
module shift_rows_bank
    import aes_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_wr_en,
    input  aes_idx_t  i_wr_idx,
    input  aes_byte_t i_wr_data,
    input  logic      i_encrypt,
    input  logic      i_clr_full,
    input  aes_idx_t  i_rd_idx,
    output logic      o_full,
    output aes_byte_t o_rd_data_c
);

    localparam aes_idx_t LAST_IDX = AES_IDX_W'(AES_BLOCK_BYTES - 1);

    aes_byte_t r_mem [AES_BLOCK_BYTES];
    logic      r_full;
    logic      r_encrypt;
    aes_idx_t  w_src_idx;

    // Writes only happen while not full and clears only while full, so set/clear never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < AES_BLOCK_BYTES; i++) begin
                r_mem[i] <= '0;
            end
            r_full    <= 1'b0;
            r_encrypt <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_idx] <= i_wr_data;
                if (i_wr_idx == '0) begin
                    r_encrypt <= i_encrypt;
                end
                if (i_wr_idx == LAST_IDX) begin
                    r_full <= 1'b1;
                end
            end
            if (i_clr_full) begin
                r_full <= 1'b0;
            end
        end
    end

    always_comb begin
        w_src_idx   = r_encrypt ? shift_src_idx(i_rd_idx) : inv_shift_src_idx(i_rd_idx);
        o_rd_data_c = r_mem[w_src_idx];
    end

    assign o_full = r_full;

endmodule

// File: rtl/shift_rows_buffer.sv
// Ping-pong ShiftRows/InvShiftRows buffer: one bank fills while the other
// drains in shifted column-major order, sustaining one byte per cycle.
module shift_rows_buffer
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    shift_rows_buffer_if.slave bus
);

    localparam aes_idx_t LAST_IDX = AES_IDX_W'(AES_BLOCK_BYTES - 1);

    aes_idx_t  r_wr_idx;
    aes_idx_t  r_rd_idx;
    logic      r_wr_ptr;
    logic      r_rd_ptr;

    logic      w_full    [AES_NUM_BANKS];
    aes_byte_t w_rd_data [AES_NUM_BANKS];
    logic      w_in_ready;
    logic      w_out_valid;
    logic      w_in_fire;
    logic      w_out_fire;

    assign w_in_ready  = !w_full[r_wr_ptr];
    assign w_out_valid = w_full[r_rd_ptr];
    assign w_in_fire   = bus.in_valid && w_in_ready;
    assign w_out_fire  = w_out_valid && bus.out_ready;

    for (genvar g = 0; g < AES_NUM_BANKS; g++) begin : gen_bank
        shift_rows_bank u_bank (
            .clk         (clk),
            .rst         (rst),
            .i_wr_en     (w_in_fire && (r_wr_ptr == 1'(g))),
            .i_wr_idx    (r_wr_idx),
            .i_wr_data   (bus.d_in),
            .i_encrypt   (bus.encrypt),
            .i_clr_full  (w_out_fire && (r_rd_ptr == 1'(g)) && (r_rd_idx == LAST_IDX)),
            .i_rd_idx    (r_rd_idx),
            .o_full      (w_full[g]),
            .o_rd_data_c (w_rd_data[g])
        );
    end

    // Byte counters wrap naturally at 16; the bank pointer flips on each wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_wr_idx <= r_wr_idx + AES_IDX_W'(1);
                if (r_wr_idx == LAST_IDX) begin
                    r_wr_ptr <= ~r_wr_ptr;
                end
            end
            if (w_out_fire) begin
                r_rd_idx <= r_rd_idx + AES_IDX_W'(1);
                if (r_rd_idx == LAST_IDX) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.d_out        = w_out_valid ? w_rd_data[r_rd_ptr] : '0;
    assign bus.out_col_last = w_out_valid && (r_rd_idx[1:0] == 2'd3);
    assign bus.out_blk_last = w_out_valid && (r_rd_idx == LAST_IDX);

endmodule

// File: tb/tb_shift_rows_buffer.sv
// Randomized bench for shift_rows_buffer with a block-level reference model
// and literal vectors for the known ShiftRows / InvShiftRows permutations.
module tb_shift_rows_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    shift_rows_buffer_if bus ();

    shift_rows_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       cl;
        logic       bl;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t       exp_q [$];
    logic [7:0] cur [$];
    bit         cur_mode;
    int         full_blocks = 0;
    int         total_in = 0;
    logic [7:0] out_log [$];
    logic       col_log [$];
    bit         prev_stall = 0;
    logic [7:0] prev_d;
    int         ready_mode = 0;

    logic [7:0] seq_in   [16] = '{8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,
                                  8'h08,8'h09,8'h0a,8'h0b,8'h0c,8'h0d,8'h0e,8'h0f};
    logic [7:0] lit_enc  [16] = '{8'h00,8'h05,8'h0a,8'h0f,8'h04,8'h09,8'h0e,8'h03,
                                  8'h08,8'h0d,8'h02,8'h07,8'h0c,8'h01,8'h06,8'h0b};
    logic [7:0] lit_dec  [16] = '{8'h00,8'h0d,8'h0a,8'h07,8'h04,8'h01,8'h0e,8'h0b,
                                  8'h08,8'h05,8'h02,8'h0f,8'h0c,8'h09,8'h06,8'h03};
    logic [7:0] fips_in  [16] = '{8'hd4,8'h27,8'h11,8'hae,8'he0,8'hbf,8'h98,8'hf1,
                                  8'hb8,8'hb4,8'h5d,8'he5,8'h1e,8'h41,8'h52,8'h30};
    logic [7:0] fips_out [16] = '{8'hd4,8'hbf,8'h5d,8'h30,8'he0,8'hb4,8'h52,8'hae,
                                  8'hb8,8'h41,8'h11,8'hf1,8'h1e,8'h27,8'h98,8'he5};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output byte k = 4c + r comes from column (c +/- r) mod 4 of the same row.
    function automatic int src_of(input int k, input bit enc);
        int c;
        int r;
        c = k / 4;
        r = k % 4;
        return enc ? 4 * ((c + r) % 4) + r : 4 * ((c - r + 4) % 4) + r;
    endfunction

    // Model and compare: outputs are stable at the falling edge, and whatever
    // handshakes are seen here are the ones the next rising edge commits.
    always @(negedge clk) begin
        bit   m_valid;
        bit   m_ready;
        exp_t e;
        if (rst) begin
            cur.delete();
            exp_q.delete();
            full_blocks = 0;
            prev_stall  = 0;
            check("rst_out_valid", 32'(bus.out_valid), 0);
            check("rst_in_ready", 32'(bus.in_ready), 1);
            check("rst_d_out", 32'(bus.d_out), 0);
            check("rst_col_last", 32'(bus.out_col_last), 0);
            check("rst_blk_last", 32'(bus.out_blk_last), 0);
        end else begin
            m_valid = full_blocks > 0;
            m_ready = full_blocks < 2;
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("in_ready", 32'(bus.in_ready), 32'(m_ready));
            if (m_valid && exp_q.size() > 0) begin
                e = exp_q[0];
                check("d_out", 32'(bus.d_out), 32'(e.b));
                check("col_last", 32'(bus.out_col_last), 32'(e.cl));
                check("blk_last", 32'(bus.out_blk_last), 32'(e.bl));
            end
            if (prev_stall) check("stall_hold", 32'(bus.d_out), 32'(prev_d));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d     = bus.d_out;
            if (m_valid && bus.out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                out_log.push_back(bus.d_out);
                col_log.push_back(bus.out_col_last);
                if (e.bl) full_blocks--;
            end
            if (bus.in_valid && m_ready) begin
                if (cur.size() == 0) cur_mode = bus.encrypt;
                cur.push_back(bus.d_in);
                total_in++;
                if (cur.size() == 16) begin
                    for (int k = 0; k < 16; k++) begin
                        e.b  = cur[src_of(k, cur_mode)];
                        e.cl = (k % 4) == 3;
                        e.bl = k == 15;
                        exp_q.push_back(e);
                    end
                    cur.delete();
                    full_blocks++;
                end
            end
        end
    end

    // Downstream ready pattern, updated shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    task automatic put(input logic [7:0] b, input bit enc);
        bit fired;
        int guard;
        bus.in_valid = 1'b1;
        bus.d_in     = b;
        bus.encrypt  = enc;
        guard        = 0;
        do begin
            @(negedge clk);
            fired = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!fired && guard < 2000);
        if (!fired) check("put_timeout", 32'(fired), 1);
    endtask

    task automatic send_block(input logic [7:0] b [16], input bit enc, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            put(b[i], enc);
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.d_in     = 8'($urandom);
                bus.encrypt  = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
        bus.d_in     = 8'($urandom);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic check_log(input string name, input logic [7:0] lit [16]);
        check({name, "_len"}, 32'(out_log.size()), 16);
        if (out_log.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check(name, 32'(out_log[i]), 32'(lit[i]));
                check({name, "_col"}, 32'(col_log[i]), 32'((i % 4) == 3));
            end
        end
        out_log.delete();
        col_log.delete();
    endtask

    task automatic rand_block(output logic [7:0] b [16]);
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] rb [16];
        int         base;
        bus.in_valid  = 1'b0;
        bus.d_in      = '0;
        bus.encrypt   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_block(seq_in, 1'b1, 1'b0);
        drain();
        check_log("enc_seq", lit_enc);

        send_block(seq_in, 1'b0, 1'b0);
        drain();
        check_log("dec_seq", lit_dec);

        send_block(fips_in, 1'b1, 1'b0);
        drain();
        check_log("fips_r1", fips_out);

        // Three blocks against a blocked output: only two banks can fill.
        ready_mode = 2;
        @(posedge clk);
        #1;
        base = total_in;
        fork
            begin
                rand_block(rb); send_block(rb, 1'b1, 1'b0);
                rand_block(rb); send_block(rb, 1'b0, 1'b0);
                rand_block(rb); send_block(rb, 1'b1, 1'b0);
            end
            begin
                repeat (40) @(negedge clk);
                check("accepted_before_release", 32'(total_in - base), 32);
                ready_mode = 0;
            end
        join
        drain();
        check("three_block_count", 32'(out_log.size()), 48);
        out_log.delete();
        col_log.delete();

        ready_mode = 1;
        for (int n = 0; n < 8; n++) begin
            rand_block(rb);
            send_block(rb, 1'($urandom), 1'b1);
        end
        drain();
        check("random_count", 32'(out_log.size()), 128);
        out_log.delete();
        col_log.delete();

        // Reset in the middle of a block, then a clean block.
        ready_mode = 0;
        for (int i = 0; i < 7; i++) put(8'($urandom), 1'b1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 32'(bus.out_valid), 0);
        check("post_rst_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        send_block(seq_in, 1'b1, 1'b0);
        drain();
        check_log("post_rst_enc", lit_enc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_rows_buffer.md
SHIFT_ROWS_BUFFER -- requirements
Module: shift_rows_buffer

Interface
REQ-001 Parameters SHALL be none; all widths and sizes SHALL come from aes_pkg (AES_BLOCK_BYTES = 16, AES_BYTE_W = 8).
REQ-002 Timing: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  async active-high reset.
REQ-005 encrypt  in  1  1 = ShiftRows, 0 = InvShiftRows; sampled with byte 0 of each block.
REQ-006 in_valid  in  1  d_in carries a valid byte.
REQ-007 in_ready  out  1  buffer can accept a byte.
REQ-008 d_in  in  8  input state byte, column-major order (index = 4*col + row).
REQ-009 out_valid  out  1  d_out carries a valid shifted byte.
REQ-010 out_ready  in  1  downstream MixColumns stage accepts the byte.
REQ-011 d_out  out  8  output byte, column-major order of the shifted state.
REQ-012 out_col_last  out  1  high with the row-3 byte of each output column; marks a MixColumns column boundary.
REQ-013 out_blk_last  out  1  high with output byte 15 of a block.

Function
REQ-014 Storage SHALL be two 16-byte banks (ping-pong): one filled while the other drains.
REQ-015 Input transfer SHALL occur on in_valid & in_ready; wr_idx (0..15) SHALL write d_in into the write bank at wr_idx, then increment.
REQ-016 On the transfer with wr_idx = 15, the write bank SHALL be marked full, wr_idx SHALL wrap to 0, and the write pointer SHALL toggle banks.
REQ-017 encrypt SHALL be latched per bank on the transfer with wr_idx = 0 and held until that bank drains.
REQ-018 in_ready SHALL be 0 when the current write bank is full; otherwise 1.
REQ-019 out_valid SHALL be 1 when the read bank is full.
REQ-020 Output transfer SHALL occur on out_valid & out_ready; rd_idx (0..15) SHALL increment on each transfer.
REQ-021 With rd_idx = 4*c + r, d_out SHALL be the read bank byte at index 4*((c+r) mod 4) + r in encrypt mode, and at 4*((c-r) mod 4) + r in decrypt mode (2-bit wrap arithmetic).
REQ-022 On the transfer with rd_idx = 15, the read bank SHALL be cleared to not-full, rd_idx SHALL wrap to 0, and the read pointer SHALL toggle banks.
REQ-023 out_col_last SHALL equal out_valid & (rd_idx[1:0] = 3); out_blk_last SHALL equal out_valid & (rd_idx = 15).
REQ-024 d_out and mode SHALL remain stable while out_valid & !out_ready.
REQ-025 Latency: the first output byte SHALL be valid the cycle after byte 15 is accepted; sustained throughput SHALL be 1 byte/cycle in and out.
REQ-026 If a bank completes filling in the same cycle the other bank drains byte 15, both events SHALL take effect with no lost cycle or byte.
REQ-027 With both banks full, in_ready SHALL be 0 until the read bank's byte 15 is transferred.
REQ-028 d_in and encrypt SHALL be ignored when no input transfer occurs.

Reset
REQ-029 On rst: wr_idx, rd_idx, both pointers and both full flags SHALL be 0, banks and latched modes SHALL be 0, out_valid = 0, in_ready = 1, d_out = 0, out_col_last = 0, out_blk_last = 0.
REQ-030 Reset asserted mid-block SHALL discard all partial and full blocks; the first byte after release SHALL be treated as byte 0.

Structure
REQ-031 aes_pkg SHALL hold AES_BLOCK_BYTES, AES_BYTE_W, the byte type, and the shift/inverse-shift source-index functions, which shall be shared with the key and MixColumns stages.
REQ-032 One sub-module, shift_rows_bank (16x8 register bank with write port, full flag, latched mode and combinational indexed read), SHALL be instantiated twice.

Verification
REQ-033 Encrypt, bytes 00..0f back-to-back with out_ready = 1 -> outputs 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b; first output one cycle after byte 0f; out_col_last on the 4th, 8th, 12th and 16th bytes.
REQ-034 Decrypt, bytes 00..0f -> outputs 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03.
REQ-035 FIPS-197 round 1, encrypt, input d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> outputs d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
REQ-036 Three blocks back-to-back (encrypt, decrypt, encrypt) with out_ready held 0 for 40 cycles -> in_ready drops after 32 bytes; after release all 48 bytes emerge in order with the correct per-block mode.
REQ-037 Random out_ready stalls -> d_out held stable while stalled; no bytes dropped or duplicated.
REQ-038 rst asserted after 7 bytes of a block -> out_valid = 0 and in_ready = 1; the next 16 bytes form a complete block with correct output.
